control_bombas_alternadas: RTL

Sequential pump-scheduling controller for the two-pump tank-filling system. It owns outputs B1/B2 and decides, from the enable switch and the two level sensors, whether zero, one or both pumps run. The leading pump alternates each completed fill to equalise wear. A minimum dwell time prevents pump chatter, and an inconsistent sensor pair is latched as a fault. Sits between the debounced front-panel/sensor inputs and the pump drivers, replacing the free-running Mealy output decode with a registered, time-qualified FSM.

---
 rtl/control_bombas_alternadas.sv | 103 ++++++++++
 1 files changed

// File: rtl/control_bombas_alternadas.sv
// Two-pump tank-fill controller: registered inputs, dwell-qualified FSM, lead-pump alternation
// and a sticky sensor-fault latch. All outputs come straight from flops.
module control_bombas_alternadas #(
  parameter int unsigned MIN_DWELL = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic I,
  input  logic S_L,
  input  logic S_H,
  input  logic fault_clr,
  output logic B1,
  output logic B2,
  output logic lead,
  output logic fault
);

  typedef enum logic [1:0] {StIdle, StFillOne, StFillTwo, StFault} state_e;

  localparam logic [CNT_W-1:0] DwellMax = CNT_W'(MIN_DWELL);

  logic             r_rst_n;
  logic             r_en, r_sl, r_sh, r_clr;
  logic             r_inv_prev;
  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lead, w_lead_d;
  logic             r_b1, r_b2, r_fault;
  logic             w_inv, w_fault_det, w_dwell;

  // Assertion is immediate; release takes effect one edge after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_n <= 1'b0;
    else          r_rst_n <= 1'b1;
  end

  assign w_inv       = r_sh & ~r_sl;
  assign w_fault_det = w_inv & r_inv_prev;
  assign w_dwell     = (r_cnt == DwellMax);

  always_comb begin
    w_state_d = r_state;
    w_lead_d  = r_lead;
    if (w_fault_det) begin
      w_state_d = StFault;
    end else if (r_state == StFault) begin
      if (r_clr && !w_inv) w_state_d = StIdle;
    end else if (!r_en) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:    if (!r_sl && w_dwell) w_state_d = StFillTwo;
        StFillTwo: if (r_sl && w_dwell) w_state_d = StFillOne;
        StFillOne: begin
          if (!r_sl && w_dwell) begin
            w_state_d = StFillTwo;
          end else if (r_sh && w_dwell) begin
            // Completed fill: hand the lead to the other pump.
            w_state_d = StIdle;
            w_lead_d  = ~r_lead;
          end
        end
        default:   w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_en       <= 1'b0;
      r_sl       <= 1'b0;
      r_sh       <= 1'b0;
      r_clr      <= 1'b0;
      r_inv_prev <= 1'b0;
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_lead     <= 1'b0;
      r_b1       <= 1'b0;
      r_b2       <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_en       <= I;
      r_sl       <= S_L;
      r_sh       <= S_H;
      r_clr      <= fault_clr;
      r_inv_prev <= w_inv;
      r_state    <= w_state_d;
      if (w_state_d != r_state) r_cnt <= '0;
      else if (!w_dwell)        r_cnt <= r_cnt + 1'b1;
      r_lead     <= w_lead_d;
      r_b1       <= (w_state_d == StFillTwo) | ((w_state_d == StFillOne) & ~w_lead_d);
      r_b2       <= (w_state_d == StFillTwo) | ((w_state_d == StFillOne) & w_lead_d);
      r_fault    <= (w_state_d == StFault);
    end
  end

  assign B1    = r_b1;
  assign B2    = r_b2;
  assign lead  = r_lead;
  assign fault = r_fault;

endmodule
